// File: rtl/logic_unit_pkg.sv
// ---------------------------------------------------------------------------
// logic_unit_pkg
//   Shared definitions for the logic-unit scheduler: the logic unit's
//   operation codes and the scheduler FSM state encodings.
// ---------------------------------------------------------------------------
package logic_unit_pkg;

   // Select codes understood by the shared combinational logic unit
   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_XOR = 2'b10,
      OP_NOT = 2'b11
   } lu_op_e;

   // Scheduler FSM; 2'b11 is unused and recovers to ST_IDLE
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_RESP  = 2'b10
   } sched_state_e;

   // Response owner tags
   localparam logic OWNER_A = 1'b0;
   localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-input round-robin arbiter with a one-hot grant.
//   Ports:
//     clk, rst  clock / async active-high reset (reset favours req[0])
//     req       request vector, bit 0 = A, bit 1 = B
//     advance   pulse when the served request completes
//     served    index of the request that was served (sampled on advance)
//     gnt       one-hot grant, combinational from req and priority
// ---------------------------------------------------------------------------
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   input  logic       served,
   output logic [1:0] gnt
);

   // prio_q = 0 favours req[0], 1 favours req[1]
   logic prio_q;
   logic prio_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

   // Favour whichever requester was not just served
   always_comb begin
      prio_d = prio_q;
      if (advance) begin
         prio_d = ~served;
      end
   end

   // Contention resolved by priority; a lone request passes straight through
   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = prio_q ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/logic_unit_sched.sv
// ---------------------------------------------------------------------------
// logic_unit_sched
//   Shares one combinational logic unit between requesters A and B.
//   Ports:
//     clk, rst                      clock / async active-high reset
//     a_valid/a_ready/a_x/a_y/a_op  requester A op port (ready pulses on grant)
//     b_valid/b_ready/b_x/b_y/b_op  requester B op port
//     lu_x, lu_y, lu_sel            registered inputs to the logic unit
//     lu_out                        logic unit result (combinational)
//     rsp_valid/rsp_ready           response handshake
//     rsp_data, rsp_owner           captured result and its owner (0=A, 1=B)
//     ops_done                      completed-response counter (wraps)
// ---------------------------------------------------------------------------
module logic_unit_sched
   import logic_unit_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                a_valid,
   output logic                a_ready,
   input  logic [DATA_W-1:0]   a_x,
   input  logic [DATA_W-1:0]   a_y,
   input  logic [1:0]          a_op,
   input  logic                b_valid,
   output logic                b_ready,
   input  logic [DATA_W-1:0]   b_x,
   input  logic [DATA_W-1:0]   b_y,
   input  logic [1:0]          b_op,
   output logic [DATA_W-1:0]   lu_x,
   output logic [DATA_W-1:0]   lu_y,
   output logic [1:0]          lu_sel,
   input  logic [2*DATA_W-1:0] lu_out,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [2*DATA_W-1:0] rsp_data,
   output logic                rsp_owner,
   output logic [CNT_W-1:0]    ops_done
);

   sched_state_e        state_q, state_d;
   logic [DATA_W-1:0]   lu_x_q, lu_y_q;
   logic [1:0]          lu_sel_q;
   logic                owner_q;
   logic [2*DATA_W-1:0] rsp_data_q;
   logic [CNT_W-1:0]    cnt_q;

   logic [1:0] req;
   logic [1:0] gnt;
   logic       grant_any;
   logic       handshake;

   // Requests are only presented to the arbiter in IDLE, so readys are 0 elsewhere
   assign req       = (state_q == ST_IDLE) ? {b_valid, a_valid} : 2'b00;
   assign grant_any = |gnt;
   assign handshake = (state_q == ST_RESP) && rsp_ready;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (handshake),
      .served  (owner_q),
      .gnt     (gnt)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (grant_any) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_RESP;
         ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      a_ready   = gnt[0];
      b_ready   = gnt[1];
      rsp_valid = (state_q == ST_RESP);
   end

   // Operand, result and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lu_x_q     <= '0;
         lu_y_q     <= '0;
         lu_sel_q   <= '0;
         owner_q    <= OWNER_A;
         rsp_data_q <= '0;
         cnt_q      <= '0;
      end else begin
         if (grant_any) begin
            lu_x_q   <= gnt[1] ? b_x  : a_x;
            lu_y_q   <= gnt[1] ? b_y  : a_y;
            lu_sel_q <= gnt[1] ? b_op : a_op;
            owner_q  <= gnt[1];
         end
         // lu_* have been stable for a full cycle by the end of ISSUE
         if (state_q == ST_ISSUE) begin
            rsp_data_q <= lu_out;
         end
         if (handshake) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign lu_x      = lu_x_q;
   assign lu_y      = lu_y_q;
   assign lu_sel    = lu_sel_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_owner = owner_q;
   assign ops_done  = cnt_q;

endmodule

// File: tb/tb_logic_unit_sched.sv
module tb_logic_unit_sched;
   import logic_unit_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_valid, b_valid, a_ready, b_ready;
   logic [3:0] a_x, a_y, b_x, b_y, lu_x, lu_y;
   logic [1:0] a_op, b_op, lu_sel;
   logic [7:0] lu_out, rsp_data, ops_done;
   logic       rsp_valid, rsp_ready, rsp_owner;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Logic unit model
   always_comb begin
      lu_out = 8'h00;
      case (lu_sel)
         2'b00: lu_out = {4'h0, lu_x & lu_y};
         2'b01: lu_out = {4'h0, lu_x | lu_y};
         2'b10: lu_out = {4'h0, lu_x ^ lu_y};
         2'b11: lu_out = ~{lu_y, lu_x};
         default: lu_out = 8'h00;
      endcase
   end

   logic_unit_sched #(.DATA_W(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y), .a_op(a_op),
      .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_y(b_y), .b_op(b_op),
      .lu_x(lu_x), .lu_y(lu_y), .lu_sel(lu_sel), .lu_out(lu_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_owner(rsp_owner), .ops_done(ops_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; rsp_ready = 1'b0;
      a_valid = 0; a_x = 0; a_y = 0; a_op = 0;
      b_valid = 0; b_x = 0; b_y = 0; b_op = 0;
      tick(); tick();
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_ops_done", ops_done, 0);
      check("reset_lu", {lu_x, lu_y, lu_sel}, 0);
      check("reset_readys", {a_ready, b_ready}, 0);
      rst = 1'b0;
      tick();

      // A only: C & A -> 08
      a_valid = 1; a_x = 4'hC; a_y = 4'hA; a_op = OP_AND; rsp_ready = 1;
      #1;
      check("a_only_ready", {a_ready, b_ready}, 2'b10);
      tick();
      a_valid = 0; #1;
      check("a_only_ready_drop", a_ready, 0);
      check("a_only_lu", {lu_x, lu_y, lu_sel}, {4'hC, 4'hA, 2'b00});
      tick();
      check("a_only_rsp_valid", rsp_valid, 1);
      check("a_only_rsp", {rsp_owner, rsp_data}, {1'b0, 8'h08});
      tick();
      $display("op A AND C,A -> data=%02h owner=%0d", 8'h08, 0);
      check("a_only_done", ops_done, 1);
      check("a_only_idle", rsp_valid, 0);

      // B only: NOT 3,5 -> AC
      b_valid = 1; b_x = 4'h3; b_y = 4'h5; b_op = OP_NOT;
      #1;
      check("b_only_ready", {a_ready, b_ready}, 2'b01);
      tick();
      b_valid = 0;
      tick();
      check("b_only_rsp", {rsp_valid, rsp_owner, rsp_data}, {1'b1, 1'b1, 8'hAC});
      tick();
      $display("op B NOT 3,5 -> data=%02h owner=%0d", rsp_data, rsp_owner);
      check("b_only_done", ops_done, 2);

      // Both valid continuously: alternate A(0E), B(06)
      a_valid = 1; a_x = 4'hC; a_y = 4'hA; a_op = OP_OR;
      b_valid = 1; b_x = 4'hC; b_y = 4'hA; b_op = OP_XOR;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("rr_grant", {a_ready, b_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
         tick(); tick();
         check("rr_rsp", {rsp_valid, rsp_owner, rsp_data},
               (k % 2 == 0) ? {1'b1, 1'b0, 8'h0E} : {1'b1, 1'b1, 8'h06});
         $display("rr op %0d -> data=%02h owner=%0d", k, rsp_data, rsp_owner);
         tick();
      end
      a_valid = 0; b_valid = 0;
      check("rr_done", ops_done, 6);

      // Back-pressure: A AND C,A with rsp_ready low for 10 cycles
      rsp_ready = 0;
      a_valid = 1; a_op = OP_AND; b_valid = 1;
      #1;
      check("bp_grant", {a_ready, b_ready}, 2'b10);
      tick(); tick();
      for (int k = 0; k < 10; k++) begin
         check("bp_hold", {rsp_valid, rsp_data, a_ready, b_ready, lu_x, lu_y, lu_sel},
               {1'b1, 8'h08, 1'b0, 1'b0, 4'hC, 4'hA, 2'b00});
         tick();
      end
      check("bp_no_count", ops_done, 6);
      rsp_ready = 1;
      tick();
      $display("bp op A AND C,A -> data=%02h released", rsp_data);
      check("bp_single_hs", {rsp_valid, ops_done}, {1'b0, 8'd7});
      check("bp_next_favours_b", {a_ready, b_ready}, 2'b01);
      a_valid = 0; b_valid = 0;
      tick();
      check("bp_no_extra", {rsp_valid, ops_done}, {1'b0, 8'd7});

      // Reset mid-RESP
      rsp_ready = 0;
      a_valid = 1; a_x = 4'h3; a_y = 4'h5; a_op = OP_XOR;
      tick(); a_valid = 0; tick();
      check("rst_pre_resp", {rsp_valid, rsp_data}, {1'b1, 8'h06});
      #2 rst = 1'b1; #1;
      check("rst_mid_rsp_valid", rsp_valid, 0);
      check("rst_mid_lu", {lu_x, lu_y, lu_sel, rsp_data}, 0);
      check("rst_mid_ops_done", ops_done, 0);
      $display("reset mid-RESP -> rsp_valid=%0d ops_done=%0d", rsp_valid, ops_done);
      tick();
      rst = 1'b0;
      rsp_ready = 1;
      tick();
      check("rst_no_rsp", {rsp_valid, ops_done}, 0);

      // 256 back-to-back ops from A: counter wraps FF -> 00
      a_valid = 1; a_x = 4'h3; a_y = 4'h5; a_op = OP_OR;
      for (int k = 0; k < 255; k++) begin
         tick(); tick(); tick();
      end
      check("wrap_ff", ops_done, 8'hFF);
      tick(); tick();
      check("wrap_last_rsp", {rsp_valid, rsp_data}, {1'b1, 8'h07});
      tick();
      check("wrap_00", ops_done, 8'h00);
      $display("256 ops -> ops_done=%02h", ops_done);
      a_valid = 0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
